// File: rtl/if_fetch_unit_pkg.sv
// rv_pipe_pkg: shared pipeline widths, the NOP encoding
// and the fetch FSM state type.
package rv_pipe_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch stage
// (master) and instruction memory (slave).
interface if_fetch_unit_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) ();

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit_skid.sv
// fetch_skid_buf: one-entry {instr, pc} holding slot used
// when a fetch lands while ID is stalled.
module fetch_skid_buf #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_unload,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_full
);

  logic               r_full;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
    end else if (i_clear | i_unload) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_full  = r_full;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch stage owning the fetch PC, the imem
// handshake, ID back-pressure and EX redirects.
module if_fetch_unit #(
  parameter int              PC_W     = rv_pipe_pkg::PC_W,
  parameter int              INSTR_W  = rv_pipe_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  if_fetch_unit_if.master    imem,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               valid_out
);

  import rv_pipe_pkg::*;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    r_redir_hold;
  logic [PC_W-1:0]    r_pc_out;
  logic [INSTR_W-1:0] r_instr;
  logic               r_kill;
  logic               r_valid;

  logic [PC_W-1:0]    w_target;
  logic [INSTR_W-1:0] w_skid_instr;
  logic [PC_W-1:0]    w_skid_pc;
  logic               w_skid_full;
  logic               w_req;
  logic               w_ack;
  logic               w_fresh;
  logic               w_slot_free;
  logic               w_load_out;
  logic               w_load_skid;
  logic               w_unload;

  assign w_target    = {redirect_pc[PC_W-1:2], 2'b00};
  assign w_ack       = w_req & imem.imem_ack;
  // ack data is usable only if no redirect killed it
  assign w_fresh     = w_ack & ~r_kill & ~redirect_valid;
  assign w_slot_free = ~r_valid | ~stall_i;
  assign w_load_out  = w_fresh & w_slot_free;
  assign w_load_skid = w_fresh & ~w_slot_free;
  assign w_unload    = (r_state == FULL) & w_skid_full
                     & ~stall_i & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FETCH: if (w_load_skid) w_state_nxt = FULL;
      FULL: begin
        if (redirect_valid | ~stall_i) w_state_nxt = FETCH;
      end
    endcase
  end

  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      FETCH: w_req = ~reset;
      FULL:  w_req = 1'b0;
    endcase
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;

  // an un-acked request stays on the bus; kill drops its data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_redir_hold <= RESET_PC;
      r_kill       <= 1'b0;
    end else if (redirect_valid) begin
      if (w_ack | (r_state == FULL)) begin
        r_fetch_pc <= w_target;
        r_kill     <= 1'b0;
      end else begin
        r_redir_hold <= w_target;
        r_kill       <= 1'b1;
      end
    end else if (w_ack) begin
      r_fetch_pc <= r_kill ? r_redir_hold
                           : r_fetch_pc + PC_W'(4);
      r_kill     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_instr  <= INSTR_W'(NOP_INSTR);
      r_pc_out <= '0;
    end else if (redirect_valid) begin
      r_valid <= 1'b0;
      r_instr <= INSTR_W'(NOP_INSTR);
    end else if (w_load_out) begin
      r_valid  <= 1'b1;
      r_instr  <= imem.imem_rdata;
      r_pc_out <= r_fetch_pc;
    end else if (w_unload) begin
      r_valid  <= 1'b1;
      r_instr  <= w_skid_instr;
      r_pc_out <= w_skid_pc;
    end else if (~stall_i) begin
      r_valid <= 1'b0;
    end
  end

  fetch_skid_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load_skid),
    .i_unload (w_unload),
    .i_clear  (redirect_valid),
    .i_instr  (imem.imem_rdata),
    .i_pc     (r_fetch_pc),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc),
    .o_full   (w_skid_full)
  );

  assign instruction_out = r_instr;
  assign pc_out          = r_pc_out;
  assign valid_out       = r_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and random stimulus against an
// in-order stream model of the fetch stage.
module tb_if_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam logic [63:0] NOP    = 64'h13;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] instruction_out;
  logic [63:0] pc_out;
  logic        valid_out;

  int nchk  = 0;
  int npass = 0;
  int mem_lat;
  int rand_lat = 0;
  int rnd_lat;
  int wcnt;

  logic [63:0] exp_pc;
  logic [63:0] cons_q[$];
  logic [63:0] ack_q[$];

  logic        pv_rst = 1'b1;
  logic        pv_req, pv_ack, pv_val, pv_stall, pv_redir;
  logic [63:0] pv_addr, pv_pc;
  logic [31:0] pv_instr;

  if_fetch_unit_if #(.PC_W(64), .INSTR_W(32)) imem ();

  if_fetch_unit #(
    .PC_W     (64),
    .INSTR_W  (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem            (imem),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] qget(int i);
    return (i < cons_q.size()) ? cons_q[i] : 64'hBAD0_BAD0;
  endfunction

  function automatic logic [63:0] aget(int i);
    return (i < ack_q.size()) ? ack_q[i] : 64'hBAD0_BAD0;
  endfunction

  // instruction memory: ack after lat cycles of req
  assign imem.imem_ack = imem.imem_req &&
    (wcnt >= (rand_lat != 0 ? rnd_lat : mem_lat));
  assign imem.imem_rdata = imem.imem_ack ?
    memf(imem.imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (reset) begin
      wcnt    <= 0;
      rnd_lat <= 2;
    end else if (imem.imem_req) begin
      if (imem.imem_ack) begin
        wcnt    <= 0;
        rnd_lat <= int'($urandom_range(1, 3));
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic monitor();
    if (reset) begin
      exp_pc = RST_PC;
      pv_rst = 1'b1;
      return;
    end
    if (!pv_rst && pv_req && !pv_ack) begin
      chk("hs_req", 64'(imem.imem_req), 64'd1);
      chk("hs_addr", imem.imem_addr, pv_addr);
    end
    if (!pv_rst && pv_val && pv_stall && !pv_redir) begin
      chk("hold_valid", 64'(valid_out), 64'd1);
      chk("hold_pc", pc_out, pv_pc);
      chk("hold_instr", 64'(instruction_out),
          64'(pv_instr));
    end
    if (imem.imem_req && imem.imem_ack)
      ack_q.push_back(imem.imem_addr);
    if (valid_out && !stall_i) begin
      chk("cons_pc", pc_out, exp_pc);
      chk("cons_instr", 64'(instruction_out),
          64'(memf(exp_pc)));
      cons_q.push_back(pc_out);
      exp_pc = exp_pc + 64'd4;
    end
    if (redirect_valid)
      exp_pc = {redirect_pc[63:2], 2'b00};
    pv_rst   = 1'b0;
    pv_req   = imem.imem_req;
    pv_ack   = imem.imem_ack;
    pv_addr  = imem.imem_addr;
    pv_val   = valid_out;
    pv_stall = stall_i;
    pv_redir = redirect_valid;
    pv_pc    = pc_out;
    pv_instr = instruction_out;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset(int lat);
    reset          = 1'b1;
    stall_i        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_lat        = lat;
    rand_lat       = 0;
    cyc();
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_instr", 64'(instruction_out), NOP);
    chk("rst_pc", pc_out, 64'd0);
    chk("rst_req", 64'(imem.imem_req), 64'd0);
    cyc();
    reset = 1'b0;
    cons_q.delete();
    ack_q.delete();
    #1;
    chk("first_req", 64'(imem.imem_req), 64'd1);
    chk("first_addr", imem.imem_addr, RST_PC);
  endtask

  task automatic next_addr(string tag, logic [63:0] from,
                           logic [63:0] exp);
    int n = 0;
    while (n < 30 && !(imem.imem_req &&
           imem.imem_addr != from)) begin
      cyc();
      n++;
    end
    chk({tag, "_tmo"}, 64'(n < 30), 64'd1);
    chk(tag, imem.imem_addr, exp);
  endtask

  initial begin
    int n;

    // 1: streaming, latency 1
    do_reset(1);
    run(10);
    chk("t1_a0", aget(0), 64'h1000);
    chk("t1_a1", aget(1), 64'h1004);
    chk("t1_a2", aget(2), 64'h1008);
    chk("t1_c0", qget(0), 64'h1000);
    chk("t1_c1", qget(1), 64'h1004);
    chk("t1_c2", qget(2), 64'h1008);

    // 2: stall across the 0x1004 ack fills the skid
    do_reset(1);
    n = 0;
    while (n < 20 && !valid_out) begin cyc(); n++; end
    chk("t2_wait", 64'(n < 20), 64'd1);
    stall_i = 1'b1;
    run(2);
    chk("t2_req", 64'(imem.imem_req), 64'd0);
    chk("t2_val", 64'(valid_out), 64'd1);
    chk("t2_pc", pc_out, 64'h1000);
    cyc();
    stall_i = 1'b0;
    run(10);
    chk("t2_c0", qget(0), 64'h1000);
    chk("t2_c1", qget(1), 64'h1004);
    chk("t2_c2", qget(2), 64'h1008);

    // 3: redirect on the same cycle as the 0x1008 ack
    do_reset(1);
    n = 0;
    while (n < 20 && !(imem.imem_ack &&
           imem.imem_addr == 64'h1008)) begin
      cyc();
      n++;
    end
    chk("t3_wait", 64'(n < 20), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("t3_val", 64'(valid_out), 64'd0);
    chk("t3_instr", 64'(instruction_out), NOP);
    chk("t3_req", 64'(imem.imem_req), 64'd1);
    chk("t3_addr", imem.imem_addr, 64'h2000);
    run(8);
    chk("t3_c1", qget(1), 64'h1004);
    chk("t3_c2", qget(2), 64'h2000);

    // 4a: redirect mid-wait, latency 3
    do_reset(3);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    cyc();
    redirect_valid = 1'b0;
    chk("t4a_req", 64'(imem.imem_req), 64'd1);
    chk("t4a_hold", imem.imem_addr, 64'h1000);
    next_addr("t4a_next", 64'h1000, 64'h2000);

    // 4b: second redirect while kill pending wins
    do_reset(3);
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2000;
    cyc();
    redirect_pc    = 64'h3000;
    cyc();
    redirect_valid = 1'b0;
    chk("t4b_ack", 64'(imem.imem_ack), 64'd1);
    chk("t4b_hold", imem.imem_addr, 64'h1000);
    cyc();
    chk("t4b_addr", imem.imem_addr, 64'h3000);
    chk("t4b_val", 64'(valid_out), 64'd0);
    run(10);
    chk("t4b_c0", qget(0), 64'h3000);

    // 5: alignment of target and PC wrap
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2003;
    cyc();
    redirect_valid = 1'b0;
    next_addr("t5_align", 64'h1000, 64'h2000);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    next_addr("t5_tgt", 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC);
    next_addr("t5_wrap", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    run(6);
    chk("t5_c0", qget(0), 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5_c1", qget(1), 64'h0);

    // 6: reset while FULL
    do_reset(1);
    stall_i = 1'b1;
    run(4);
    chk("t6_req", 64'(imem.imem_req), 64'd0);
    chk("t6_val", 64'(valid_out), 64'd1);
    chk("t6_pc", pc_out, 64'h1000);
    do_reset(1);
    run(8);
    chk("t6_c0", qget(0), 64'h1000);
    chk("t6_c1", qget(1), 64'h1004);

    // random latency, stalls and redirects
    do_reset(1);
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      stall_i = ($urandom_range(0, 3) == 0);
      if (!redirect_valid && $urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = {$urandom, $urandom};
      end else begin
        redirect_valid = 1'b0;
      end
      cyc();
    end
    stall_i        = 1'b0;
    redirect_valid = 1'b0;
    run(20);
    chk("rnd_progress", 64'(cons_q.size() >= 100), 64'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
